// File: rtl/ahb_master_arbiter.sv
// ahb_master_arbiter
// Round-robin arbiter sharing one AHB master command port among NUM_REQ
// requesters. The winner holds the port for a whole burst: counted for
// SINGLE/WRAPx/INCRx, or until it flags req_last for INCR. An error on any
// accepted beat aborts the burst.
//
// Ports
//   clk, rst                  clock, async active-high reset
//   req_*                     packed per-requester vectors, slice i = requester i
//   req_ready / req_error     one-hot (or zero) to the current owner
//   req_rdata                 read data, shared by all requesters
//   grant                     current owner, one-hot or zero
//   m_*                       master port toward the AHB master interface

// Per-requester slice: masks this requester's command onto the shared
// AND-OR mux and routes handshake/error back when it is the owner.
module ahb_arb_slice #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          sel,
    input  logic          valid,
    input  logic          write,
    input  logic [AW-1:0] addr,
    input  logic [2:0]    size,
    input  logic [DW-1:0] wdata,
    input  logic          beat_ok,
    input  logic          err,
    output logic          valid_m,
    output logic          write_m,
    output logic [AW-1:0] addr_m,
    output logic [2:0]    size_m,
    output logic [DW-1:0] wdata_m,
    output logic          ready,
    output logic          error
);
    assign valid_m = sel & valid;
    assign write_m = sel & write;
    assign addr_m  = {AW{sel}} & addr;
    assign size_m  = {3{sel}} & size;
    assign wdata_m = {DW{sel}} & wdata;
    assign ready   = sel & beat_ok;
    assign error   = sel & err;
endmodule

module ahb_master_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int AHB_ADDR_WIDTH = 32,
    parameter int AHB_DATA_WIDTH = 32
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_REQ-1:0]                  req_valid,
    input  logic [NUM_REQ-1:0]                  req_last,
    input  logic [NUM_REQ*AHB_ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ-1:0]                  req_write,
    input  logic [NUM_REQ*3-1:0]                req_size,
    input  logic [NUM_REQ*3-1:0]                req_burst,
    input  logic [NUM_REQ*AHB_DATA_WIDTH-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]                  req_ready,
    output logic [AHB_DATA_WIDTH-1:0]           req_rdata,
    output logic [NUM_REQ-1:0]                  req_error,
    output logic [NUM_REQ-1:0]                  grant,
    output logic                                m_sel,
    output logic                                m_valid,
    output logic [AHB_ADDR_WIDTH-1:0]           m_addr,
    output logic                                m_write,
    output logic [2:0]                          m_size,
    output logic [2:0]                          m_burst,
    output logic [AHB_DATA_WIDTH-1:0]           m_wdata,
    input  logic                                m_ready,
    input  logic [AHB_DATA_WIDTH-1:0]           m_rdata,
    input  logic                                m_master_error,
    input  logic                                m_other_error
);
    localparam int AW = AHB_ADDR_WIDTH;
    localparam int DW = AHB_DATA_WIDTH;
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [2:0] BURST_INCR = 3'd1;

    typedef enum logic {IDLE, OWNED} state_t;

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [2:0]           burst_q, burst_d;
    logic [4:0]           remaining_q, remaining_d;

    // Packed per-requester views of the flat port vectors.
    logic [NUM_REQ-1:0][AW-1:0] addr_v;
    logic [NUM_REQ-1:0][DW-1:0] wdata_v;
    logic [NUM_REQ-1:0][2:0]    size_v;
    logic [NUM_REQ-1:0][2:0]    burst_v;

    assign addr_v  = req_addr;
    assign wdata_v = req_wdata;
    assign size_v  = req_size;
    assign burst_v = req_burst;

    // Beats per burst code; INCR is unbounded and never consults the count.
    function automatic logic [4:0] burst_beats(input logic [2:0] b);
        case (b)
            3'd0:       burst_beats = 5'd1;
            3'd1:       burst_beats = 5'd0;
            3'd2, 3'd3: burst_beats = 5'd4;
            3'd4, 3'd5: burst_beats = 5'd8;
            default:    burst_beats = 5'd16;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Round-robin pick: first requester at or after rr_ptr, wrapping.
    // ------------------------------------------------------------------
    logic               any_req;
    logic               found;
    logic [PW-1:0]      win_idx;
    logic [PW-1:0]      win_next;
    logic [NUM_REQ-1:0] win_onehot;
    int                 idx;

    always_comb begin
        any_req = |req_valid;
        found   = 1'b0;
        win_idx = '0;
        idx     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!found && req_valid[idx]) begin
                found   = 1'b1;
                win_idx = PW'(idx);
            end
        end
    end

    assign win_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
    assign win_next   = (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + PW'(1);

    // ------------------------------------------------------------------
    // Owner datapath: per-requester slices feeding an AND-OR mux.
    // grant_q is zero outside OWNED, so every slice is masked off then.
    // ------------------------------------------------------------------
    logic [NUM_REQ-1:0]         valid_m, write_m, ready_v, error_v;
    logic [NUM_REQ-1:0][AW-1:0] addr_m;
    logic [NUM_REQ-1:0][2:0]    size_m;
    logic [NUM_REQ-1:0][DW-1:0] wdata_m;
    logic                       beat_ok;
    logic                       err;
    logic                       owner_last;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
        ahb_arb_slice #(.AW(AW), .DW(DW)) u_slice (
            .sel     (grant_q[i]),
            .valid   (req_valid[i]),
            .write   (req_write[i]),
            .addr    (addr_v[i]),
            .size    (size_v[i]),
            .wdata   (wdata_v[i]),
            .beat_ok (beat_ok),
            .err     (err),
            .valid_m (valid_m[i]),
            .write_m (write_m[i]),
            .addr_m  (addr_m[i]),
            .size_m  (size_m[i]),
            .wdata_m (wdata_m[i]),
            .ready   (ready_v[i]),
            .error   (error_v[i])
        );
    end

    always_comb begin
        m_addr  = '0;
        m_size  = '0;
        m_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            m_addr  = m_addr  | addr_m[i];
            m_size  = m_size  | size_m[i];
            m_wdata = m_wdata | wdata_m[i];
        end
    end

    assign m_valid    = |valid_m;
    assign m_write    = |write_m;
    assign beat_ok    = m_valid & m_ready;
    assign err        = (m_master_error | m_other_error) & beat_ok;
    assign owner_last = |(grant_q & req_last);

    assign m_sel     = (state_q == OWNED);
    assign m_burst   = m_sel ? burst_q : 3'd0;
    assign grant     = grant_q;
    assign req_ready = ready_v;
    assign req_error = error_v;
    // Outside ownership nobody consumes read data; keep the port quiet.
    assign req_rdata = m_sel ? m_rdata : '0;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        burst_d     = burst_q;
        remaining_d = remaining_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d     = OWNED;
                    grant_d     = win_onehot;
                    rr_ptr_d    = win_next;
                    burst_d     = burst_v[win_idx];
                    remaining_d = burst_beats(burst_v[win_idx]);
                end
            end
            OWNED: begin
                if (beat_ok) begin
                    // INCR loads 0; keep it there rather than wrapping.
                    if (remaining_q != 5'd0)
                        remaining_d = remaining_q - 5'd1;
                    if (err ||
                        ((burst_q == BURST_INCR) ? owner_last : (remaining_q == 5'd1))) begin
                        state_d     = IDLE;
                        grant_d     = '0;
                        remaining_d = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            burst_q     <= '0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_q     <= burst_d;
            remaining_q <= remaining_d;
        end
    end
endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Directed bench for ahb_master_arbiter (NUM_REQ=4, 32-bit address/data).
module tb_ahb_master_arbiter;
    localparam int NR = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid, req_last, req_write;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*3-1:0]   req_size, req_burst;
    logic [NR*DW-1:0]  req_wdata;
    logic [NR-1:0]     req_ready, req_error, grant;
    logic [DW-1:0]     req_rdata;
    logic              m_sel, m_valid, m_write;
    logic [AW-1:0]     m_addr;
    logic [2:0]        m_size, m_burst;
    logic [DW-1:0]     m_wdata;
    logic              m_ready;
    logic [DW-1:0]     m_rdata;
    logic              m_master_error, m_other_error;

    int n_cmp  = 0;
    int n_fail = 0;

    ahb_master_arbiter #(.NUM_REQ(NR), .AHB_ADDR_WIDTH(AW), .AHB_DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_last(req_last), .req_addr(req_addr),
        .req_write(req_write), .req_size(req_size), .req_burst(req_burst),
        .req_wdata(req_wdata), .req_ready(req_ready), .req_rdata(req_rdata),
        .req_error(req_error), .grant(grant),
        .m_sel(m_sel), .m_valid(m_valid), .m_addr(m_addr), .m_write(m_write),
        .m_size(m_size), .m_burst(m_burst), .m_wdata(m_wdata),
        .m_ready(m_ready), .m_rdata(m_rdata),
        .m_master_error(m_master_error), .m_other_error(m_other_error)
    );

    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic last,
                           input logic [AW-1:0] a, input logic w,
                           input logic [2:0] burst, input logic [DW-1:0] d);
        req_valid[i]          = v;
        req_last[i]           = last;
        req_addr[i*AW +: AW]  = a;
        req_write[i]          = w;
        req_size[i*3 +: 3]    = 3'd2;
        req_burst[i*3 +: 3]   = burst;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = '0; req_last = '0; req_write = '0; req_addr = '0;
        req_size = '0; req_burst = '0; req_wdata = '0;
        m_ready = 1'b1; m_rdata = 32'h1234_5678;
        m_master_error = 1'b0; m_other_error = 1'b0;
        #3;
        n_cmp++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant got %b want 0000", grant); end
        n_cmp++; if (m_sel !== 1'b0) begin n_fail++; $display("FAIL reset_m_sel got %b want 0", m_sel); end
        n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready got %b want 0000", req_ready); end
        n_cmp++; if (req_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h want 0", req_rdata); end
        step(); step();
        rst = 1'b0;
        m_rdata = '0;
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g [9];
        exp_g = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                  4'b0000, 4'b1000, 4'b0000, 4'b0001};
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b0, 32'h10 * i, 1'b0, 3'd0, 32'h0);
        m_ready = 1'b1;
        for (int c = 0; c < 9; c++) begin
            step();
            n_cmp++; if (grant !== exp_g[c]) begin n_fail++; $display("FAIL rr_grant[%0d] got %b want %b", c, grant, exp_g[c]); end
            n_cmp++; if (req_ready !== exp_g[c]) begin n_fail++; $display("FAIL rr_ready[%0d] got %b want %b", c, req_ready, exp_g[c]); end
        end
        step();
        req_valid = '0;
        #1;
        n_cmp++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL rr_idle got %b want 0000", grant); end
    endtask

    task automatic test_single();
        set_req(1, 1'b1, 1'b0, 32'h100, 1'b1, 3'd0, 32'hA5);
        m_ready = 1'b0;
        #1;
        n_cmp++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL single_pre got %b want 0000", grant); end
        step();
        n_cmp++; if (grant !== 4'b0010) begin n_fail++; $display("FAIL single_grant got %b want 0010", grant); end
        n_cmp++; if (m_sel !== 1'b1) begin n_fail++; $display("FAIL single_sel got %b want 1", m_sel); end
        n_cmp++; if (m_addr !== 32'h100) begin n_fail++; $display("FAIL single_addr got %h want 100", m_addr); end
        n_cmp++; if (m_write !== 1'b1 || m_wdata !== 32'hA5 || m_size !== 3'd2) begin
            n_fail++; $display("FAIL single_cmd got w=%b d=%h s=%0d want w=1 d=a5 s=2", m_write, m_wdata, m_size); end
        n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL single_noready got %b want 0000", req_ready); end
        m_ready = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL single_ready got %b want 0010", req_ready); end
        step();
        req_valid[1] = 1'b0;
        #1;
        n_cmp++; if (grant !== 4'b0000 || m_sel !== 1'b0) begin
            n_fail++; $display("FAIL single_release got g=%b sel=%b want g=0000 sel=0", grant, m_sel); end
    endtask

    task automatic test_fixed_burst();
        set_req(0, 1'b1, 1'b0, 32'h200, 1'b1, 3'd3, 32'h11);
        set_req(1, 1'b1, 1'b0, 32'h300, 1'b1, 3'd0, 32'h22);
        m_ready = 1'b1;
        step();
        for (int b = 0; b < 4; b++) begin
            n_cmp++; if (grant !== 4'b0001 || req_ready !== 4'b0001) begin
                n_fail++; $display("FAIL burst_beat[%0d] got g=%b r=%b want g=0001 r=0001", b, grant, req_ready); end
            n_cmp++; if (m_burst !== 3'd3) begin n_fail++; $display("FAIL burst_code[%0d] got %0d want 3", b, m_burst); end
            step();
        end
        req_valid[0] = 1'b0;
        #1;
        n_cmp++; if (grant !== 4'b0000 || m_sel !== 1'b0) begin
            n_fail++; $display("FAIL burst_bubble got g=%b sel=%b want g=0000 sel=0", grant, m_sel); end
        step();
        n_cmp++; if (grant !== 4'b0010 || m_addr !== 32'h300) begin
            n_fail++; $display("FAIL burst_next got g=%b a=%h want g=0010 a=300", grant, m_addr); end
        step();
        req_valid[1] = 1'b0;
        #1;
        n_cmp++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL burst_done got %b want 0000", grant); end
    endtask

    task automatic test_incr_stall();
        logic mr [8];
        int beats;
        mr = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        beats = 0;
        set_req(2, 1'b1, 1'b0, 32'h400, 1'b0, 3'd1, 32'h0);
        m_ready = 1'b1;
        step();
        for (int c = 0; c < 8; c++) begin
            m_ready     = mr[c];
            req_last[2] = (beats == 5);
            m_rdata     = 32'hDEAD_0000 + c;
            #1;
            n_cmp++; if (grant !== 4'b0100) begin n_fail++; $display("FAIL incr_grant[%0d] got %b want 0100", c, grant); end
            n_cmp++; if (req_ready !== (mr[c] ? 4'b0100 : 4'b0000)) begin
                n_fail++; $display("FAIL incr_ready[%0d] got %b want %b", c, req_ready, mr[c] ? 4'b0100 : 4'b0000); end
            n_cmp++; if (req_rdata !== 32'hDEAD_0000 + c) begin
                n_fail++; $display("FAIL incr_rdata[%0d] got %h want %h", c, req_rdata, 32'hDEAD_0000 + c); end
            if (mr[c]) beats++;
            step();
        end
        req_valid[2] = 1'b0;
        req_last[2]  = 1'b0;
        m_ready      = 1'b1;
        #1;
        n_cmp++; if (grant !== 4'b0000 || m_sel !== 1'b0) begin
            n_fail++; $display("FAIL incr_release got g=%b sel=%b want g=0000 sel=0", grant, m_sel); end
    endtask

    task automatic test_error();
        set_req(3, 1'b1, 1'b0, 32'h500, 1'b1, 3'd4, 32'h33);
        m_ready = 1'b1;
        step();
        n_cmp++; if (grant !== 4'b1000 || req_ready !== 4'b1000 || req_error !== 4'b0000) begin
            n_fail++; $display("FAIL err_beat1 got g=%b r=%b e=%b want 1000/1000/0000", grant, req_ready, req_error); end
        step();
        m_other_error = 1'b1;
        #1;
        n_cmp++; if (req_error !== 4'b1000) begin n_fail++; $display("FAIL err_flag got %b want 1000", req_error); end
        step();
        m_other_error = 1'b0;
        req_valid[3]  = 1'b0;
        #1;
        n_cmp++; if (grant !== 4'b0000 || m_valid !== 1'b0 || req_error !== 4'b0000) begin
            n_fail++; $display("FAIL err_abort got g=%b v=%b e=%b want 0000/0/0000", grant, m_valid, req_error); end
        step();
        n_cmp++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL err_nobeat3 got %b want 0000", grant); end
        // Master-side error on the first beat of an INCR.
        set_req(0, 1'b1, 1'b0, 32'h600, 1'b0, 3'd1, 32'h0);
        step();
        m_master_error = 1'b1;
        #1;
        n_cmp++; if (req_error !== 4'b0001) begin n_fail++; $display("FAIL merr_flag got %b want 0001", req_error); end
        step();
        m_master_error = 1'b0;
        req_valid[0]   = 1'b0;
        #1;
        n_cmp++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL merr_abort got %b want 0000", grant); end
    endtask

    task automatic test_reset_mid();
        set_req(0, 1'b1, 1'b0, 32'h700, 1'b1, 3'd0, 32'h44);
        m_ready = 1'b0;
        step();
        n_cmp++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL rstmid_pre got %b want 0001", grant); end
        m_ready = 1'b1;
        #1;
        rst = 1'b1;
        #1;
        n_cmp++; if (grant !== 4'b0000 || m_sel !== 1'b0 || m_valid !== 1'b0 || req_ready !== 4'b0000) begin
            n_fail++; $display("FAIL rstmid_out got g=%b sel=%b v=%b r=%b want all 0", grant, m_sel, m_valid, req_ready); end
        step();
        rst = 1'b0;
        req_valid[0] = 1'b0;
        m_rdata = 32'hFFFF_FFFF;
        step();
        n_cmp++; if (grant !== 4'b0000 || m_sel !== 1'b0 || m_addr !== 32'h0 || m_burst !== 3'd0 ||
                     req_rdata !== 32'h0 || req_error !== 4'b0000 || m_wdata !== 32'h0) begin
            n_fail++; $display("FAIL idle_outputs got g=%b sel=%b a=%h b=%0d rd=%h e=%b want all 0",
                               grant, m_sel, m_addr, m_burst, req_rdata, req_error); end
        // rr_ptr must be back at 0: requester 0 beats requester 1.
        set_req(0, 1'b1, 1'b0, 32'h800, 1'b0, 3'd0, 32'h0);
        set_req(1, 1'b1, 1'b0, 32'h900, 1'b0, 3'd0, 32'h0);
        m_ready = 1'b0;
        step();
        n_cmp++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL rstmid_ptr got %b want 0001", grant); end
        req_valid = '0;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_fixed_burst();
        test_incr_stall();
        test_error();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/ahb_master_arbiter.md
# ahb_master_arbiter

Round-robin arbiter that shares one AHB master interface command port among `NUM_REQ` testbench or RTL requesters. It holds the grant for the full burst, counting fixed-length bursts, or until a requester-flagged last beat for INCR. It muxes the command/write data of the winner onto the master port and routes ready, read data and error status back to it. It sits directly in front of the AHB master interface.

## Interface

Parameters:

- `NUM_REQ`, 4: number of requesters (2..8)
- `AHB_ADDR_WIDTH`, 32: address width
- `AHB_DATA_WIDTH`, 32: data width

Clock, reset and requester side (packed per-requester vectors; requester i occupies slice i):

- `clk`  in  1  clock
- `rst`  in  1  reset; one clock domain, asynchronous assert, active-high
- `req_valid`  in  NUM_REQ  beat request
- `req_last`  in  NUM_REQ  marks final beat (INCR only)
- `req_addr`  in  NUM_REQ*AHB_ADDR_WIDTH  beat address
- `req_write`  in  NUM_REQ  1 = write
- `req_size`  in  NUM_REQ*3  HSIZE code
- `req_burst`  in  NUM_REQ*3  HBURST code; sampled only on first beat
- `req_wdata`  in  NUM_REQ*AHB_DATA_WIDTH  write data
- `req_ready`  out  NUM_REQ  beat accepted (one-hot or zero)
- `req_rdata`  out  AHB_DATA_WIDTH  read data, common to all requesters
- `req_error`  out  NUM_REQ  beat ended with error (one-hot or zero)
- `grant`  out  NUM_REQ  current owner, one-hot or zero

Master port side:

- `m_sel`  out  1  owner present
- `m_valid`  out  1  beat valid
- `m_addr`  out  AHB_ADDR_WIDTH  address
- `m_write`  out  1  direction
- `m_size`  out  3  size
- `m_burst`  out  3  burst code of locked burst
- `m_wdata`  out  AHB_DATA_WIDTH  write data
- `m_ready`  in  1  beat complete
- `m_rdata`  in  AHB_DATA_WIDTH  read data
- `m_master_error`  in  1  error from master interface
- `m_other_error`  in  1  error from slave/other

## Operation

- States: IDLE, OWNED.
- **IDLE**
  - `grant`=0 and `m_sel`=0.
  - If any `req_valid` is set, pick the first set bit at or after `rr_ptr` (wrapping modulo `NUM_REQ`).
  - Register the one-hot `grant` and go to OWNED.
  - Set `rr_ptr` = winner+1, wrapping.
  - Capture the winner's `req_burst` into `burst_q`.
- **Beat-count load from `burst_q`:** SINGLE(0)=1; INCR(1)=unbounded; WRAP4/INCR4(2,3)=4; WRAP8/INCR8(4,5)=8; WRAP16/INCR16(6,7)=16. The counter is 5 bits.
- **OWNED**
  - `m_sel`=1.
  - `m_valid`, `m_addr`, `m_write`, `m_size` and `m_wdata` are combinational muxes of the owner's inputs.
  - `m_burst`=`burst_q`.
  - `req_ready[owner]` = `m_valid` & `m_ready`.
  - `req_rdata` = `m_rdata`, passed through combinationally.
  - A beat is accepted when `m_valid` & `m_ready`; each accepted beat decrements `remaining`.
- **Release: return to IDLE on the accepted beat when any of these holds:**
  - the counted burst reaches `remaining`==1;
  - INCR with `req_last[owner]`=1;
  - the error condition below.
- **Error:**
  - `err` = (`m_master_error` | `m_other_error`) & `m_valid` & `m_ready`.
  - `req_error[owner]`=`err`.
  - Any error aborts the burst; the remaining beats are dropped and the state returns to IDLE.
- **Owner drops `req_valid` mid-burst:** keep ownership, `m_valid`=0, counter holds. This is legal and inserts idle beats.
- **Non-owners:** `req_ready`=0 and `req_error`=0.
- **New requests while OWNED:** ignored until IDLE.
- **Reset asserted in any state:**
  - immediately: state=IDLE, `grant`=0, `rr_ptr`=0, `burst_q`=0, `remaining`=0;
  - all outputs read 0.

## Timing

- Arbitration latency: a request seen in IDLE at edge N gives `grant` and `m_sel` high from cycle N+1; the first beat can be accepted in cycle N+1.
- Release latency: final beat accepted at edge M gives IDLE in cycle M+1, with `m_sel`=0. The earliest next grant is visible in cycle M+2, so there is one bubble cycle between owners.
- Back-to-back beats within a burst have zero added latency; throughput is 1 beat/cycle when `m_ready` is held high.
- `req_ready`, `req_rdata` and `req_error` are combinational from master inputs in the same cycle.
- Simultaneous requests are resolved purely by `rr_ptr`; there are no fixed priorities.
- `m_ready` high while `m_valid`=0 has no effect.

## Test plan

- **Reset values:** assert `rst` mid-cycle during OWNED → `grant`, `m_sel`, `m_valid` and `req_ready` read 0 in that same cycle; after release with no requests, all outputs remain 0.
- **Single beat:** `req_valid`=4'b0010, SINGLE, write `addr`=0x100 → cycle 1: `grant`=0010 and `m_addr`=0x100. With `m_ready`=1, `req_ready`=0010 for one cycle, then IDLE.
- **Fixed burst:** requester 0 issues INCR4 while requester 1 also requests, `m_ready` always 1 → requester 0 gets 4 consecutive ready beats, 1 bubble cycle, then `grant`=0010.
- **Round-robin:** all 4 requesters issue SINGLE continuously → grant order 0,1,2,3,0 with one bubble between grants.
- **INCR with last and stall:** requester 2 issues INCR with 6 beats, `m_ready` low on beat 3 for 2 cycles, `req_last` on beat 6 → grant is held through the stall and released after beat 6.
- **Error abort:** requester 3 issues WRAP8, `m_other_error`=1 with `m_ready` on beat 2 → `req_error`=1000 for one cycle, IDLE next cycle, no beat 3 issued.
